// File: rtl/neuron_mac.sv
// neuron_mac: multiply-accumulate datapath for one MLP neuron.
// Streams numWeight signed activations, reads the matching weight from the
// neuron's weight memory (1-cycle read latency), accumulates the products,
// adds the bias and emits one signed sum per vector with a 1-cycle pulse.
// Optional feature macro: NEURON_SAT_EN (saturating accumulate and bias add);
// when it is undefined both adds wrap as plain two's complement.
module neuron_mac #(
    parameter int numWeight    = 784,
    parameter int addressWidth = 10,
    parameter int dataWidth    = 16
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            in_valid,
    input  logic signed [dataWidth-1:0]     in_data,
    output logic                            in_ready,
    output logic                            w_ren,
    output logic        [addressWidth-1:0]  w_radd,
    input  logic signed [dataWidth-1:0]     w_in,
    input  logic signed [2*dataWidth-1:0]   bias,
    output logic                            out_valid,
    output logic signed [2*dataWidth-1:0]   out_data
);

    localparam int AW = 2 * dataWidth;
    localparam logic signed [AW-1:0] SUM_MAX = {1'b0, {(AW-1){1'b1}}};
    localparam logic signed [AW-1:0] SUM_MIN = {1'b1, {(AW-1){1'b0}}};
    localparam logic [addressWidth-1:0] LAST_ADDR = addressWidth'(numWeight - 1);

    typedef enum logic [1:0] {
        ACCEPT = 2'd0,
        W1     = 2'd1,
        W2     = 2'd2,
        OUT    = 2'd3
    } state_t;

    state_t                   state;
    state_t                   state_next;
    logic [addressWidth-1:0]  cnt;
    logic                     accept;
    logic signed [dataWidth-1:0] d1;
    logic                     v1;
    logic signed [AW-1:0]     prod;
    logic                     v2;
    logic signed [AW-1:0]     acc;

    // Sum of two accumulator-width values, clamped or wrapped by build option.
    function automatic logic signed [AW-1:0] add_sum(
        input logic signed [AW-1:0] a,
        input logic signed [AW-1:0] b
    );
`ifdef NEURON_SAT_EN
        logic signed [AW:0] s;
        s = {a[AW-1], a} + {b[AW-1], b};
        if (s[AW] != s[AW-1])
            return s[AW] ? SUM_MIN : SUM_MAX;
        else
            return s[AW-1:0];
`else
        return a + b;
`endif
    endfunction

    assign in_ready = (state == ACCEPT);
    assign accept   = in_valid & in_ready;
    // The weight memory samples enable and address on the accepting edge.
    assign w_ren    = accept;
    assign w_radd   = cnt;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= ACCEPT;
        else
            state <= state_next;
    end

    // Next state: stay in ACCEPT until the last input, then three drain cycles.
    always_comb begin
        state_next = state;
        case (state)
            ACCEPT:  if (accept && cnt == LAST_ADDR) state_next = W1;
            W1:      state_next = W2;
            W2:      state_next = OUT;
            OUT:     state_next = ACCEPT;
            default: state_next = ACCEPT;
        endcase
    end

    // Weight address counter, wrapping after the last input of a vector.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (accept)
            cnt <= (cnt == LAST_ADDR) ? '0 : cnt + addressWidth'(1);
    end

    // Align input with the weight arriving one cycle later, then multiply.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d1   <= '0;
            v1   <= 1'b0;
            prod <= '0;
            v2   <= 1'b0;
        end else begin
            d1   <= in_data;
            v1   <= accept;
            prod <= d1 * w_in;
            v2   <= v1;
        end
    end

    // Accumulate valid products; clear once the result has been taken in OUT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            acc <= '0;
        else if (state == OUT)
            acc <= '0;
        else if (v2)
            acc <= add_sum(acc, prod);
    end

    // Result register: bias add in OUT with a single-cycle valid pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            out_valid <= (state == OUT);
            if (state == OUT)
                out_data <= add_sum(acc, bias);
        end
    end

endmodule
